// File: rtl/exm_issue_ctrl.sv
// exm_issue_ctrl: issue gate between decode and the execute/memory stage (exm).
//
// Tracks the destination registers of in-flight instructions in an in-order
// queue. Issue stalls on read-after-write hazards against that queue and when
// the queue is full. A taken branch (flush_i) clears the queue and holds exm
// input-valid low for DRAIN_CYCLES cycles so exm clears its pipeline registers.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   issue_*                 instruction offered by decode / accept handshake
//   exm_ready_i/exm_valid_o hand-off into exm (exm_valid_o is zero latency)
//   wb_*                    retirement of the oldest in-flight instruction
//   flush_i                 taken branch from exm
//   squash_o                high while draining after a flush
//   pending_o               queue occupancy
//   err_o                   sticky retirement protocol error
module exm_issue_ctrl #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DRAIN_CYCLES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [4:0]               issue_rs1_i,
    input  logic                     issue_rs1_used_i,
    input  logic [4:0]               issue_rs2_i,
    input  logic                     issue_rs2_used_i,
    input  logic                     issue_rd_write_i,
    input  logic [4:0]               issue_rd_i,
    input  logic                     exm_ready_i,
    output logic                     exm_valid_o,
    input  logic                     wb_valid_i,
    input  logic                     wb_write_i,
    input  logic [4:0]               wb_addr_i,
    input  logic                     flush_i,
    output logic                     squash_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     err_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e            state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [PtrW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q;
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  wr_q;
    logic [4:0]        rd_q [DEPTH];
    logic              err_q;

    logic hazard, full, empty, fire, pop, wb_err;
    logic head_wr;
    logic [4:0] head_rd;

    // Hazard check looks only at registered entries, so an entry retiring
    // this cycle still blocks its consumer until the register file is written.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && wr_q[i]) begin
                if (issue_rs1_used_i && (issue_rs1_i != 5'd0) && (rd_q[i] == issue_rs1_i)) begin
                    hazard = 1'b1;
                end
                if (issue_rs2_used_i && (issue_rs2_i != 5'd0) && (rd_q[i] == issue_rs2_i)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        full          = (count_q == CntW'(DEPTH));
        empty         = (count_q == '0);
        head_wr       = wr_q[head_q];
        head_rd       = rd_q[head_q];
        issue_ready_o = !rst_i && (state_q == StRun) && !hazard && !full && exm_ready_i
                        && !flush_i;
        fire          = issue_valid_i && issue_ready_o;
        exm_valid_o   = fire;
        // The queue is always empty in StFlush, so no pop can occur there.
        pop           = wb_valid_i && !empty && (state_q == StRun);
        wb_err        = wb_valid_i && ((state_q == StFlush) || empty
                        || (wb_write_i != head_wr) || (head_wr && (wb_addr_i != head_rd)));
        squash_o      = (state_q == StFlush);
        pending_o     = count_q;
        err_o         = err_q;
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            StRun: begin
                if (flush_i) begin
                    state_d = StFlush;
                    drain_d = DrainW'(DRAIN_CYCLES - 1);
                end
            end
            StFlush: begin
                if (flush_i) begin
                    drain_d = DrainW'(DRAIN_CYCLES - 1);
                end else if (drain_q == '0) begin
                    state_d = StRun;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (wb_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Pop and push never touch the same slot: that needs head==tail, i.e.
    // empty (no pop) or full (no fire).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            wr_q    <= '0;
        end else if (flush_i) begin
            // Any same-cycle retirement was already checked; the queue is dropped.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PtrW'(1);
            end
            if (fire) begin
                vld_q[tail_q] <= 1'b1;
                wr_q[tail_q]  <= issue_rd_write_i && (issue_rd_i != 5'd0);
                tail_q        <= tail_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(fire) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            rd_q[tail_q] <= issue_rd_i;
        end
    end

endmodule

// File: tb/tb_exm_issue_ctrl.sv
module tb_exm_issue_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       issue_valid_i, issue_ready_o;
    logic [4:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic       issue_rs1_used_i, issue_rs2_used_i, issue_rd_write_i;
    logic       exm_ready_i, exm_valid_o;
    logic       wb_valid_i, wb_write_i;
    logic [4:0] wb_addr_i;
    logic       flush_i, squash_o, err_o;
    logic [$clog2(DEPTH):0] pending_o;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int exp_q[$];          // cycles in which exm_valid_o must be high
    logic [5:0] model_q[$]; // {write, rd} of in-flight instructions, oldest first

    exm_issue_ctrl #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_rs1_i(issue_rs1_i), .issue_rs1_used_i(issue_rs1_used_i),
        .issue_rs2_i(issue_rs2_i), .issue_rs2_used_i(issue_rs2_used_i),
        .issue_rd_write_i(issue_rd_write_i), .issue_rd_i(issue_rd_i),
        .exm_ready_i(exm_ready_i), .exm_valid_o(exm_valid_o),
        .wb_valid_i(wb_valid_i), .wb_write_i(wb_write_i), .wb_addr_i(wb_addr_i),
        .flush_i(flush_i), .squash_o(squash_o), .pending_o(pending_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every exm hand-off must match the next expected fire cycle.
    always @(negedge clk) begin
        if (exm_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL exm_fire: unexpected exm_valid_o at cycle %0d, expected none", cyc);
            end else begin
                check("exm_fire_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        issue_valid_i = 0; issue_rs1_i = 0; issue_rs1_used_i = 0; issue_rs2_i = 0;
        issue_rs2_used_i = 0; issue_rd_write_i = 0; issue_rd_i = 0; exm_ready_i = 1;
        wb_valid_i = 0; wb_write_i = 0; wb_addr_i = 0; flush_i = 0;
    endtask

    task automatic issue(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                         input logic u2, input logic w, input logic [4:0] d);
        issue_valid_i = 1; issue_rs1_i = s1; issue_rs1_used_i = u1; issue_rs2_i = s2;
        issue_rs2_used_i = u2; issue_rd_write_i = w; issue_rd_i = d;
    endtask

    task automatic retire();
        logic [5:0] e;
        e = model_q.pop_front();
        wb_valid_i = 1; wb_write_i = e[5]; wb_addr_i = e[4:0];
    endtask

    task automatic tick(input bit exp_fire);
        if (exp_fire) begin
            exp_q.push_back(cyc);
            model_q.push_back({issue_rd_write_i && (issue_rd_i != 5'd0), issue_rd_i});
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst_i = 1;
        // Outputs gated while reset is held, even with a valid request.
        for (int i = 0; i < 2; i++) begin
            issue(0, 0, 0, 0, 1, 1);
            #1;
            check("rst_ready", issue_ready_o, 0);
            check("rst_exm_valid", exm_valid_o, 0);
            tick(0);
        end
        rst_i = 0;
        check("rst_pending", pending_o, 0);
        check("rst_squash", squash_o, 0);
        check("rst_err", err_o, 0);

        // Single instruction and retirement; exm backpressure blocks issue.
        issue(0, 0, 0, 0, 1, 1); exm_ready_i = 0; #1;
        check("exm_not_ready", issue_ready_o, 0);
        tick(0);
        issue(0, 0, 0, 0, 1, 1); #1;
        check("t1_ready", issue_ready_o, 1);
        tick(1);
        check("t1_pending1", pending_o, 1);
        retire(); tick(0);
        check("t1_pending0", pending_o, 0);
        check("t1_err", err_o, 0);

        // RAW on rs1: stalls through the retiring cycle, issues the cycle after.
        issue(0, 0, 0, 0, 1, 5); tick(1);
        issue(5, 1, 0, 0, 1, 6); #1;
        check("raw1_stall", issue_ready_o, 0);
        tick(0);
        issue(5, 1, 0, 0, 1, 6); retire(); #1;
        check("raw1_retiring_blocks", issue_ready_o, 0);
        tick(0);
        issue(5, 1, 0, 0, 1, 6); #1;
        check("raw1_release", issue_ready_o, 1);
        tick(1);
        // RAW on rs2.
        issue(0, 0, 6, 1, 1, 7); #1;
        check("raw2_stall", issue_ready_o, 0);
        tick(0);
        retire(); tick(0);
        issue(0, 0, 6, 1, 1, 7); #1;
        check("raw2_release", issue_ready_o, 1);
        tick(1);
        // x0 sources and an x0 destination never stall; x0 entry retires as non-writing.
        issue(0, 1, 0, 1, 1, 0); #1;
        check("x0_no_stall", issue_ready_o, 1);
        tick(1);
        check("x0_pending", pending_o, 2);
        retire(); tick(0);
        retire(); tick(0);
        check("x0_drained", pending_o, 0);
        check("x0_err", err_o, 0);

        // Fill to DEPTH, stall when full, then wrap pointers over 10 instructions.
        for (int i = 0; i < 4; i++) begin
            issue(0, 0, 0, 0, 1, 5'(10 + i)); tick(1);
        end
        check("full_pending", pending_o, 4);
        issue(0, 0, 0, 0, 1, 14); #1;
        check("full_stall", issue_ready_o, 0);
        tick(0);
        issue(0, 0, 0, 0, 1, 14); retire(); #1;
        check("full_pop_still_stall", issue_ready_o, 0);
        tick(0);
        check("full_after_pop", pending_o, 3);
        issue(0, 0, 0, 0, 1, 14); #1;
        check("full_resume", issue_ready_o, 1);
        tick(1);
        check("full_again", pending_o, 4);
        retire(); tick(0);
        for (int i = 0; i < 5; i++) begin
            issue(0, 0, 0, 0, 1, 5'(15 + i)); retire(); tick(1);
        end
        check("wrap_pending", pending_o, 3);
        for (int i = 0; i < 3; i++) begin
            retire(); tick(0);
        end
        check("wrap_drained", pending_o, 0);
        check("wrap_err", err_o, 0);

        // Flush with a same-cycle retirement, reload during drain, then resume.
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 0, 0, 1, 5'(20 + i)); tick(1);
        end
        issue(0, 0, 0, 0, 1, 23); retire(); flush_i = 1; #1;
        check("flush_ready", issue_ready_o, 0);
        tick(0);
        model_q.delete();
        check("flush_squash_a", squash_o, 1);
        check("flush_pending", pending_o, 0);
        issue(0, 0, 0, 0, 1, 23); flush_i = 1; #1;
        check("flush_ready_b", issue_ready_o, 0);
        tick(0);
        check("flush_squash_b", squash_o, 1);
        issue(0, 0, 0, 0, 1, 23); #1;
        check("flush_ready_c", issue_ready_o, 0);
        tick(0);
        check("flush_squash_c", squash_o, 1);
        issue(0, 0, 0, 0, 1, 23); #1;
        check("flush_ready_d", issue_ready_o, 0);
        tick(0);
        check("flush_squash_end", squash_o, 0);
        issue(0, 0, 0, 0, 1, 23); #1;
        check("flush_resume", issue_ready_o, 1);
        tick(1);
        check("flush_err", err_o, 0);
        retire(); tick(0);

        // Retire on empty queue: sticky error until reset.
        wb_valid_i = 1; wb_write_i = 1; wb_addr_i = 3; tick(0);
        check("err_empty", err_o, 1);
        tick(0); tick(0);
        check("err_sticky", err_o, 1);
        rst_i = 1; tick(0); rst_i = 0;
        check("err_cleared", err_o, 0);
        // Retire with an address that does not match the head.
        issue(0, 0, 0, 0, 1, 8); tick(1);
        void'(model_q.pop_front());
        wb_valid_i = 1; wb_write_i = 1; wb_addr_i = 9; tick(0);
        check("err_mismatch", err_o, 1);
        check("err_mismatch_popped", pending_o, 0);

        // Reset in the middle of a stall with two entries pending.
        rst_i = 1; tick(0); rst_i = 0;
        issue(0, 0, 0, 0, 1, 3); tick(1);
        issue(0, 0, 0, 0, 1, 4); tick(1);
        issue(3, 1, 0, 0, 1, 5); #1;
        check("rst_mid_stall", issue_ready_o, 0);
        tick(0);
        check("rst_mid_pending", pending_o, 2);
        rst_i = 1;
        issue(0, 0, 0, 0, 1, 5); #1;
        check("rst_mid_ready", issue_ready_o, 0);
        tick(0);
        check("rst_mid_pending0", pending_o, 0);
        check("rst_mid_squash0", squash_o, 0);
        issue(0, 0, 0, 0, 1, 5); #1;
        check("rst_held_ready", issue_ready_o, 0);
        check("rst_held_exm_valid", exm_valid_o, 0);
        tick(0);
        rst_i = 0;
        model_q.delete();
        issue(3, 1, 0, 0, 1, 5); #1;
        check("post_rst_ready", issue_ready_o, 1);
        tick(1);
        retire(); tick(0);
        check("post_rst_pending", pending_o, 0);
        check("post_rst_err", err_o, 0);

        tick(0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
